signed_accumulator: RTL and testbench

Sequential signed accumulator for the recognizer datapath. It sums a fixed-length stream of DEPTH signed W-bit terms, such as per-pixel products or adder outputs. It presents one full-precision signed sum through a valid/ready output handshake. It consumes the adder tree's results on the far side and removes the need for a combinational adder chain across a whole image.

---
 rtl/signed_accumulator_if.sv | 24 ++
 rtl/signed_accumulator.sv | 86 ++++++++
 tb/tb_signed_accumulator.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/signed_accumulator_if.sv
// Term-stream and result handshake bundle for signed_accumulator.
interface signed_accumulator_if #(
    parameter int unsigned W     = 8,
    parameter int unsigned ACC_W = 20
);
    logic                    start;
    logic                    in_valid;
    logic signed [W-1:0]     in_data;
    logic                    in_ready;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] out_data;
    logic                    busy;

    modport master (
        output start, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  start, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/signed_accumulator.sv
// Sums DEPTH signed terms into one exact ACC_W-bit result, delivered over a
// valid/ready handshake. All outputs are registered.
module signed_accumulator #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4096,
    parameter int unsigned ACC_W = W + $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    signed_accumulator_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        cnt;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic signed [ACC_W-1:0] out_data_q;
    logic                    busy_q;
    logic signed [ACC_W-1:0] sum_c;

    // Sign-extending width cast keeps the running sum exact.
    assign sum_c = acc + ACC_W'(bus.in_data);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc        <= '0;
                        cnt        <= '0;
                        state      <= ACC;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                ACC: begin
                    if (bus.in_valid) begin
                        acc <= sum_c;
                        cnt <= cnt + CNT_W'(1);
                        // Final term: publish the sum including it.
                        if (cnt == CNT_W'(DEPTH - 1)) begin
                            state       <= DONE;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_data_q  <= sum_c;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_signed_accumulator.sv
// Directed bench for signed_accumulator (DEPTH=4, W=8) with a transaction-level
// reference model checked every cycle plus literal result checks.
`timescale 1ns/100ps
module tb_signed_accumulator;
    localparam int unsigned W     = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned ACC_W = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    signed_accumulator_if #(.W(W), .ACC_W(ACC_W)) bif ();

    signed_accumulator #(.W(W), .DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif.slave)
    );

    int nvec = 0;
    int nerr = 0;
    int busy_cnt = 0;
    bit check_en = 1'b0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: idle / collecting / holding-result, with plain integer sums.
    int  m_phase = 0;
    int  m_sum   = 0;
    int  m_n     = 0;
    int  m_out   = 0;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = 0; m_sum = 0; m_n = 0; m_out = 0;
        end else if (m_phase == 0) begin
            if (bif.start) begin m_phase = 1; m_sum = 0; m_n = 0; end
        end else if (m_phase == 1) begin
            if (bif.in_valid) begin
                m_sum = m_sum + int'(bif.in_data);
                m_n   = m_n + 1;
                if (m_n == DEPTH) begin m_phase = 2; m_out = m_sum; end
            end
        end else begin
            if (bif.out_ready) m_phase = 0;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("in_ready",  64'(bif.in_ready),  64'(m_phase == 1));
            check("out_valid", 64'(bif.out_valid), 64'(m_phase == 2));
            check("busy",      64'(bif.busy),      64'(m_phase != 0));
            check("out_data",  64'(bif.out_data),  64'(m_out));
            if (bif.busy) busy_cnt++;
        end
    end

    task automatic cyc();
        @(posedge clk); #2;
    endtask

    task automatic do_start();
        bif.start = 1'b1; cyc(); bif.start = 1'b0;
    endtask

    task automatic send(input int d, input int gap);
        repeat (gap) cyc();
        bif.in_valid = 1'b1; bif.in_data = W'(d); cyc();
        bif.in_valid = 1'b0; bif.in_data = '0;
    endtask

    // Wait (bounded) for the result, check it against a literal, then handshake.
    task automatic finish_run(input string name, input int exp);
        int k = 0;
        while (!bif.out_valid && k < 30) begin cyc(); k++; end
        check({name, "_timeout"}, 64'(bif.out_valid), 64'(1));
        check(name, 64'(bif.out_data), 64'(exp));
        check({name, "_model"}, 64'(m_out), 64'(exp));
        bif.out_ready = 1'b1; cyc(); bif.out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bif.start = 1'b0; bif.in_valid = 1'b0; bif.in_data = '0; bif.out_ready = 1'b0;
        #1;
        check("rst_in_ready",  64'(bif.in_ready),  64'(0));
        check("rst_out_valid", 64'(bif.out_valid), 64'(0));
        check("rst_out_data",  64'(bif.out_data),  64'(0));
        check("rst_busy",      64'(bif.busy),      64'(0));
        repeat (2) cyc();
        rst = 1'b1; check_en = 1'b1;
        cyc();

        // Basic run with out_ready preset: busy for exactly 5 cycles.
        busy_cnt = 0;
        bif.out_ready = 1'b1;
        do_start();
        send(1, 0); send(2, 0); send(3, 0);
        send(4, 0);
        check("valid_latency", 64'(bif.out_valid), 64'(1));
        finish_run("sum_1234", 10);
        cyc();
        check("busy_cycles", 64'(busy_cnt), 64'(5));

        // Extremes and sign extension.
        do_start();
        for (int i = 0; i < 4; i++) send(-128, 0);
        finish_run("sum_neg128", -512);
        do_start();
        for (int i = 0; i < 4; i++) send(127, 0);
        finish_run("sum_pos127", 508);

        // Gaps between transfers.
        do_start();
        send(5, 0); send(-7, 2); send(100, 5); send(-3, 1);
        finish_run("sum_gaps", 95);

        // Hold result with out_ready low; start pulses must be ignored.
        do_start();
        send(9, 0); send(9, 0); send(9, 0); send(9, 0);
        for (int i = 0; i < 6; i++) begin
            bif.start = (i % 2 == 0);
            cyc();
            check("hold_valid", 64'(bif.out_valid), 64'(1));
            check("hold_data",  64'(bif.out_data),  64'(36));
            check("hold_ready", 64'(bif.in_ready),  64'(0));
        end
        bif.start = 1'b0;
        finish_run("sum_hold", 36);
        do_start();
        for (int i = 0; i < 4; i++) send(1, 0);
        finish_run("sum_after_hold", 4);

        // Asynchronous reset mid-run after two terms.
        do_start();
        send(3, 0); send(3, 0);
        @(posedge clk); #3 rst = 1'b0; #1;
        check("arst_in_ready",  64'(bif.in_ready),  64'(0));
        check("arst_out_valid", 64'(bif.out_valid), 64'(0));
        check("arst_out_data",  64'(bif.out_data),  64'(0));
        check("arst_busy",      64'(bif.busy),      64'(0));
        #3 rst = 1'b1;
        cyc(); cyc();
        check("no_stale_valid", 64'(bif.out_valid), 64'(0));
        do_start();
        for (int i = 0; i < 4; i++) send(2, 0);
        finish_run("sum_after_rst", 8);

        // start during ACC is ignored.
        do_start();
        send(10, 0);
        bif.start = 1'b1; cyc(); bif.start = 1'b0;
        send(20, 0); send(30, 0); send(40, 0);
        finish_run("sum_start_ignored", 100);

        repeat (3) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
